fifo_multi_ch_always_appear_seq: RTL and testbench

//  - NUM_CH independent circular FIFOs, each carrying data plus a valid sideband.
//  - Next generation of the single-channel always-appear FIFO.
//  - Each channel's head entry always sits on its registered output bus.
//  - Adds full/empty/count status, overflow/underflow protection with error pulses,
//    and a mode that either clears or retains a slot when it is read.
//  - Sits between systolic-array PE columns and the AXI write-back path;
//    one channel per column.

---
 rtl/fifo_multi_ch_always_appear_seq.sv | 121 ++++++++++++
 tb/tb_fifo_multi_ch_always_appear_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_multi_ch_always_appear_seq.sv
// Multi-channel circular FIFO bank. The head entry of each channel is always on its registered output.
// Port summary: clk/rst_n (async active-low), i_en global enable, per-channel i_wr/i_rd/i_data/i_valid;
//   o_data/o_valid registered head, o_full/o_empty/o_count status, o_ovf/o_udf one-cycle reject pulses.
module fifo_multi_ch_always_appear_seq #(
  parameter int DATA_WIDTH    = 8,
  parameter int VALID_WIDTH   = 1,
  parameter int DEPTH         = 8,
  parameter int NUM_CH        = 4,
  parameter bit CLEAR_ON_READ = 1'b1,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [NUM_CH-1:0]             i_wr,
  input  logic [NUM_CH-1:0]             i_rd,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  i_data,
  input  logic [NUM_CH*VALID_WIDTH-1:0] i_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]  o_data,
  output logic [NUM_CH*VALID_WIDTH-1:0] o_valid,
  output logic [NUM_CH-1:0]             o_full,
  output logic [NUM_CH-1:0]             o_empty,
  output logic [NUM_CH*CW-1:0]          o_count,
  output logic [NUM_CH-1:0]             o_ovf,
  output logic [NUM_CH-1:0]             o_udf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = DATA_WIDTH + VALID_WIDTH;

  // Entries are stored as {data, valid}.
  logic [EW-1:0]     mem_q   [NUM_CH][DEPTH];
  logic [PW-1:0]     wptr_q  [NUM_CH];
  logic [PW-1:0]     wptr_d  [NUM_CH];
  logic [PW-1:0]     rptr_q  [NUM_CH];
  logic [PW-1:0]     rptr_d  [NUM_CH];
  logic [CW-1:0]     count_q [NUM_CH];
  logic [CW-1:0]     count_d [NUM_CH];
  logic [EW-1:0]     head_q  [NUM_CH];
  logic [EW-1:0]     head_d  [NUM_CH];
  logic [EW-1:0]     wr_ent  [NUM_CH];
  logic [NUM_CH-1:0] rd_ok;
  logic [NUM_CH-1:0] wr_ok;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] udf_q, udf_d;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ent[c]  = {i_data[c*DATA_WIDTH +: DATA_WIDTH], i_valid[c*VALID_WIDTH +: VALID_WIDTH]};
      rd_ok[c]   = i_rd[c] & (count_q[c] != '0);
      // A full channel still accepts a write when a pop frees a slot in the same cycle.
      wr_ok[c]   = i_wr[c] & ((count_q[c] != CW'(DEPTH)) | rd_ok[c]);
      wptr_d[c]  = wr_ok[c] ? ptr_inc(wptr_q[c]) : wptr_q[c];
      rptr_d[c]  = rd_ok[c] ? ptr_inc(rptr_q[c]) : rptr_q[c];
      count_d[c] = count_q[c] + CW'(wr_ok[c]) - CW'(rd_ok[c]);
      ovf_d[c]   = i_wr[c] & ~wr_ok[c];
      udf_d[c]   = i_rd[c] & ~rd_ok[c];
      // Head after the edge: zero when empty; the incoming word when it lands on the
      // new head slot (write into an empty channel); otherwise the stored entry.
      if (count_d[c] == '0) begin
        head_d[c] = '0;
      end else if (wr_ok[c] && (wptr_q[c] == rptr_d[c])) begin
        head_d[c] = wr_ent[c];
      end else begin
        head_d[c] = mem_q[c][rptr_d[c]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
        head_q[c]  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[c][i] <= '0;
        end
      end
      ovf_q <= '0;
      udf_q <= '0;
    end else if (i_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        count_q[c] <= count_d[c];
        head_q[c]  <= head_d[c];
        if (CLEAR_ON_READ && rd_ok[c]) begin
          mem_q[c][rptr_q[c]] <= '0;
        end
        // Listed after the clear: on a full-channel write+pop both hit the same slot,
        // and the new word must survive.
        if (wr_ok[c]) begin
          mem_q[c][wptr_q[c]] <= wr_ent[c];
        end
      end
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      o_data[c*DATA_WIDTH +: DATA_WIDTH]   = head_q[c][EW-1:VALID_WIDTH];
      o_valid[c*VALID_WIDTH +: VALID_WIDTH] = head_q[c][VALID_WIDTH-1:0];
      o_count[c*CW +: CW]                  = count_q[c];
      o_full[c]                            = (count_q[c] == CW'(DEPTH));
      o_empty[c]                           = (count_q[c] == '0);
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;

endmodule

// File: tb/tb_fifo_multi_ch_always_appear_seq.sv
// Bench: three DUT flavours (DEPTH 8 clear-on-read, DEPTH 6 clear-on-read, DEPTH 6 retain)
// share one stimulus stream; a queue-based reference model predicts every enabled edge and a
// monitor compares each flavour's outputs against the predictions one edge later.
module tb_fifo_multi_ch_always_appear_seq;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  valid;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  ovf;
    logic [3:0]  udf;
    logic [15:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wr = '0, rd = '0, vin = '0;
  logic [31:0] din = '0;

  logic [31:0] d8_data, d6_data, dn_data;
  logic [3:0]  d8_valid, d6_valid, dn_valid;
  logic [3:0]  d8_full, d6_full, dn_full, d8_empty, d6_empty, dn_empty;
  logic [3:0]  d8_ovf, d6_ovf, dn_ovf, d8_udf, d6_udf, dn_udf;
  logic [15:0] d8_count;
  logic [11:0] d6_count, dn_count;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_multi_ch_always_appear_seq #(.DATA_WIDTH(8), .VALID_WIDTH(1), .DEPTH(8), .NUM_CH(4), .CLEAR_ON_READ(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_wr(wr), .i_rd(rd), .i_data(din), .i_valid(vin),
    .o_data(d8_data), .o_valid(d8_valid), .o_full(d8_full), .o_empty(d8_empty),
    .o_count(d8_count), .o_ovf(d8_ovf), .o_udf(d8_udf));

  fifo_multi_ch_always_appear_seq #(.DATA_WIDTH(8), .VALID_WIDTH(1), .DEPTH(6), .NUM_CH(4), .CLEAR_ON_READ(1'b1)) dut6 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_wr(wr), .i_rd(rd), .i_data(din), .i_valid(vin),
    .o_data(d6_data), .o_valid(d6_valid), .o_full(d6_full), .o_empty(d6_empty),
    .o_count(d6_count), .o_ovf(d6_ovf), .o_udf(d6_udf));

  fifo_multi_ch_always_appear_seq #(.DATA_WIDTH(8), .VALID_WIDTH(1), .DEPTH(6), .NUM_CH(4), .CLEAR_ON_READ(1'b0)) dut6n (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_wr(wr), .i_rd(rd), .i_data(din), .i_valid(vin),
    .o_data(dn_data), .o_valid(dn_valid), .o_full(dn_full), .o_empty(dn_empty),
    .o_count(dn_count), .o_ovf(dn_ovf), .o_udf(dn_udf));

  // Reference model: index = instance*4 + channel. Entries are {data, valid}.
  logic [8:0] mq [12][$];
  logic [8:0] sh [12][8];   // slot contents as the spec describes them
  int         rp [12];
  int         wp [12];
  bit         eovf [12];
  bit         eudf [12];
  exp_t       sbq [3][$];

  function automatic int dep(int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic bit cor(int k);
    return (k < 2);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 12; i++) begin
      mq[i].delete();
      rp[i] = 0; wp[i] = 0; eovf[i] = 0; eudf[i] = 0;
      for (int j = 0; j < 8; j++) sh[i][j] = '0;
    end
  endtask

  task automatic mupdate(input logic e, input logic [3:0] w, input logic [3:0] r,
                         input logic [31:0] d, input logic [3:0] v);
    if (e) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 4; c++) begin
          int  idx;
          int  sz;
          bit  rdok, wrok;
          logic [8:0] ent;
          idx  = k*4 + c;
          sz   = mq[idx].size();
          rdok = r[c] && (sz > 0);
          wrok = w[c] && ((sz < dep(k)) || rdok);
          eovf[idx] = w[c] && !wrok;
          eudf[idx] = r[c] && !rdok;
          if (rdok) begin
            void'(mq[idx].pop_front());
            if (cor(k)) sh[idx][rp[idx]] = '0;
            rp[idx] = (rp[idx] + 1) % dep(k);
          end
          if (wrok) begin
            ent = {d[c*8 +: 8], v[c]};
            mq[idx].push_back(ent);
            sh[idx][wp[idx]] = ent;
            wp[idx] = (wp[idx] + 1) % dep(k);
          end
        end
      end
    end
  endtask

  function automatic exp_t mk(int k);
    exp_t x;
    x = '0;
    for (int c = 0; c < 4; c++) begin
      int idx;
      int sz;
      logic [8:0] hd;
      idx = k*4 + c;
      sz  = mq[idx].size();
      hd  = (sz > 0) ? mq[idx][0] : 9'd0;
      x.data[c*8 +: 8] = hd[8:1];
      x.valid[c] = hd[0];
      x.full[c]  = (sz == dep(k));
      x.empty[c] = (sz == 0);
      x.ovf[c]   = eovf[idx];
      x.udf[c]   = eudf[idx];
      if (k == 0) x.count[c*4 +: 4] = 4'(sz);
      else        x.count[c*3 +: 3] = 3'(sz);
    end
    return x;
  endfunction

  function automatic exp_t act(int k);
    exp_t a;
    a = '0;
    case (k)
      0: a = '{d8_data, d8_valid, d8_full, d8_empty, d8_ovf, d8_udf, d8_count};
      1: a = '{d6_data, d6_valid, d6_full, d6_empty, d6_ovf, d6_udf, {4'b0, d6_count}};
      default: a = '{dn_data, dn_valid, dn_full, dn_empty, dn_ovf, dn_udf, {4'b0, dn_count}};
    endcase
    return a;
  endfunction

  // One clock of stimulus: drive on the falling edge, predict, then let the rising edge happen.
  task automatic step(input logic e, input logic [3:0] w, input logic [3:0] r,
                      input logic [31:0] d, input logic [3:0] v);
    @(negedge clk);
    en = e; wr = w; rd = r; din = d; vin = v;
    mupdate(e, w, r, d, v);
    for (int k = 0; k < 3; k++) sbq[k].push_back(mk(k));
    @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Monitor: after each rising edge, compare every flavour against its pending prediction.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (sbq[k].size() > 0) begin
        exp_t e, a;
        e = sbq[k].pop_front();
        a = act(k);
        n_checks++;
        if (a !== e) begin
          n_err++;
          $display("FAIL sb_inst%0d @%0t: got %h expected %h", k, $time, a, e);
        end
      end
    end
  end

  initial begin
    mreset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_empty", {28'd0, d8_empty}, 32'hF);
    chk("idle_full",  {28'd0, d8_full},  32'h0);
    chk("idle_count", {16'd0, d8_count}, 32'h0);
    chk("idle_data",  d8_data, 32'h0);
    chk("idle_valid", {28'd0, d8_valid}, 32'h0);

    // Pop an empty channel: underflow pulse for exactly one cycle.
    step(1'b1, 4'b0000, 4'b0001, 32'h0, 4'h0);
    #2 chk("udf0_pulse", {28'd0, d8_udf}, 32'h1);
    step(1'b1, 4'b0000, 4'b0000, 32'h0, 4'h0);
    #2 chk("udf0_clear", {28'd0, d8_udf}, 32'h0);
    chk("udf0_count", {16'd0, d8_count}, 32'h0);

    // Fill channel 1 with 0x11..0x18.
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0010, 4'b0000, (32'h11 + 32'(i)) << 8, 4'b0010);
    #2 chk("ch1_full", {31'd0, d8_full[1]}, 32'h1);
    chk("ch1_count8", {28'd0, d8_count[7:4]}, 32'h8);
    step(1'b1, 4'b0010, 4'b0000, 32'h0000_1900, 4'b0010);
    #2 chk("ch1_ovf", {31'd0, d8_ovf[1]}, 32'h1);
    chk("ch1_head_kept", {24'd0, d8_data[15:8]}, 32'h11);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b0000, 4'b0010, 32'h0, 4'h0);
      #2 chk("ch1_pop_data", {24'd0, d8_data[15:8]}, (i < 7) ? 32'h12 + 32'(i) : 32'h0);
    end
    chk("ch1_drained_valid", {31'd0, d8_valid[1]}, 32'h0);
    chk("ch1_drained_empty", {31'd0, d8_empty[1]}, 32'h1);

    // Channel 2: write+pop while full, then write+pop while empty.
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0100, 4'b0000, (32'h20 + 32'(i)) << 16, 4'b0100);
    step(1'b1, 4'b0100, 4'b0100, 32'h00AA_0000, 4'b0100);
    #2 chk("ch2_full_wr_rd_count", {28'd0, d8_count[11:8]}, 32'h8);
    chk("ch2_full_wr_rd_noovf", {31'd0, d8_ovf[2]}, 32'h0);
    for (int i = 0; i < 7; i++) step(1'b1, 4'b0000, 4'b0100, 32'h0, 4'h0);
    #2 chk("ch2_aa_last", {24'd0, d8_data[23:16]}, 32'hAA);
    step(1'b1, 4'b0000, 4'b0100, 32'h0, 4'h0);
    step(1'b1, 4'b0100, 4'b0100, 32'h0055_0000, 4'b0100);
    #2 chk("ch2_empty_wr_rd_count", {28'd0, d8_count[11:8]}, 32'h1);
    chk("ch2_empty_wr_rd_udf", {31'd0, d8_udf[2]}, 32'h1);
    chk("ch2_bypass_data", {24'd0, d8_data[23:16]}, 32'h55);

    // Give every channel some occupancy, then freeze with everything requested.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0000, $urandom, 4'(($urandom)));
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 4'b1111, $urandom, 4'($urandom));

    // Randomized traffic; the DEPTH 6 flavours wrap many times.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), $urandom, 4'($urandom));
    end
    step(1'b1, 4'b0000, 4'b0000, 32'h0, 4'h0);

    // Slot retention: retain flavour keeps stale words, clear flavour zeroes read slots.
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 6; j++) begin
        chk("peek_clear", {23'd0, dut6.mem_q[c][j]}, {23'd0, sh[4 + c][j]});
        chk("peek_retain", {23'd0, dut6n.mem_q[c][j]}, {23'd0, sh[8 + c][j]});
      end
    end

    // Reset mid-burst on channel 3: clears before the next rising edge.
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1000, 4'b0000, (32'hC0 + 32'(i)) << 24, 4'b1000);
    @(negedge clk);
    wr = '0; rd = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count_ch3", {28'd0, d8_count[15:12]}, 32'h0);
    chk("arst_data_ch3", {24'd0, d8_data[31:24]}, 32'h0);
    chk("arst_count_all6", {20'd0, d6_count}, 32'h0);
    chk("arst_empty", {28'd0, d8_empty}, 32'hF);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'b1000, 4'b0000, 32'h7700_0000, 4'b1000);
    step(1'b1, 4'b0000, 4'b1000, 32'h0, 4'h0);
    step(1'b1, 4'b0000, 4'b0000, 32'h0, 4'h0);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
